pixie_dma_scheduler: RTL

- Sequences CDP1861-style display DMA for the Studio II video path.
- Keeps the machine-cycle line/frame timebase and decides per line whether to request a DMA-out burst.
- Counts 1802 DMA acknowledges (SC=2'b10) and writes each fetched byte into an 8-byte line buffer for the pixel shifter.
- Generates the display interrupt and EFx flag, and flags short bursts.

---
 rtl/pixie_dma_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pixie_dma_scheduler.sv
// Display DMA scheduler for a CDP1861-style video path: machine-cycle line/frame
// timebase, per-line DMA-out bursts into an 8-byte line buffer, INT and EFx.
//
// state | meaning
// IDLE  | no burst on this line
// WAIT  | active line, waiting for the DMA start cycle
// REQ   | DMAO asserted, collecting acknowledges
// DONE  | burst finished or abandoned, waiting for the next line
module pixie_dma_scheduler #(
    parameter int CYCLES_PER_LINE = 14,
    parameter int LINES_PER_FRAME = 262,
    parameter int START_LINE      = 64,
    parameter int ACTIVE_LINES    = 128,
    parameter int INT_LINE        = 62,
    parameter int BYTES_PER_LINE  = 8,
    parameter int DMA_START_CYCLE = 2,
    parameter int DMA_DEADLINE    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_enable,
    input  logic [1:0] SC,
    input  logic       disp_on,
    input  logic       disp_off,
    input  logic [7:0] data_in,
    output logic       DMAO,
    output logic       INT,
    output logic       EFx,
    output logic       wr_en,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       line_start,
    output logic       frame_start,
    output logic [3:0] h_count,
    output logic [8:0] v_count,
    output logic       burst_error
);

    localparam logic [3:0] H_LAST    = 4'(CYCLES_PER_LINE - 1);
    localparam logic [3:0] H_DMA     = 4'(DMA_START_CYCLE);
    localparam logic [3:0] H_DEAD    = 4'(DMA_DEADLINE);
    localparam logic [8:0] V_LAST    = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] V_START   = 9'(START_LINE);
    localparam logic [8:0] V_END     = 9'(START_LINE + ACTIVE_LINES);
    localparam logic [8:0] V_INT     = 9'(INT_LINE);
    localparam logic [8:0] V_INT_CLR = 9'(INT_LINE + 2);
    localparam logic [3:0] N_BYTES   = 4'(BYTES_PER_LINE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_DONE} state_t;

    state_t     state_q, state_n;
    logic [3:0] byte_cnt, byte_cnt_n, cnt_inc;
    logic [3:0] h_n;
    logic [8:0] v_n;
    logic       h_wrap, v_wrap;
    logic       disp_en, disp_en_n;
    logic       line_enable, line_enable_n;
    logic       active_n;
    logic       int_q, int_n;
    logic       ack;
    logic       wr_en_n, err_n;

    assign h_wrap  = (h_count == H_LAST);
    assign v_wrap  = (v_count == V_LAST);
    assign ack     = clk_enable && (state_q == S_REQ) && (SC == 2'b10);
    assign cnt_inc = byte_cnt + 4'd1;

    always_comb begin
        h_n           = h_count;
        v_n           = v_count;
        disp_en_n     = disp_en;
        line_enable_n = line_enable;
        int_n         = int_q;
        if (clk_enable) begin
            h_n = h_wrap ? 4'd0 : h_count + 4'd1;
            if (h_wrap) v_n = v_wrap ? 9'd0 : v_count + 9'd1;
            if (disp_on)       disp_en_n = 1'b1;
            else if (disp_off) disp_en_n = 1'b0;
            // The strobe only reaches the burst logic at a line boundary.
            if (h_wrap) line_enable_n = disp_en_n;
            if (SC == 2'b11) int_n = 1'b0;
            if (h_wrap && v_n == V_INT_CLR) int_n = 1'b0;
            if (h_wrap && v_n == V_INT && line_enable_n) int_n = 1'b1;
            if (!disp_en_n) int_n = 1'b0;
        end
    end

    assign active_n = (v_n >= V_START) && (v_n < V_END) && line_enable_n;

    always_comb begin
        state_n    = state_q;
        byte_cnt_n = byte_cnt;
        wr_en_n    = 1'b0;
        err_n      = 1'b0;
        if (clk_enable) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (h_wrap) begin
                        state_n    = active_n ? S_WAIT : S_IDLE;
                        byte_cnt_n = 4'd0;
                    end
                end
                S_WAIT: begin
                    if (h_n == H_DMA) state_n = S_REQ;
                end
                S_REQ: begin
                    if (ack) begin
                        wr_en_n    = 1'b1;
                        byte_cnt_n = cnt_inc;
                        if (cnt_inc == N_BYTES) state_n = S_DONE;
                    end
                    if (state_n == S_REQ && h_n == H_DEAD) begin
                        state_n = S_DONE;
                        err_n   = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            byte_cnt    <= 4'd0;
            h_count     <= 4'd0;
            v_count     <= 9'd0;
            disp_en     <= 1'b0;
            line_enable <= 1'b0;
            int_q       <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= 3'd0;
            wr_data     <= 8'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            burst_error <= 1'b0;
        end else begin
            state_q     <= state_n;
            byte_cnt    <= byte_cnt_n;
            h_count     <= h_n;
            v_count     <= v_n;
            disp_en     <= disp_en_n;
            line_enable <= line_enable_n;
            int_q       <= int_n;
            wr_en       <= wr_en_n;
            burst_error <= err_n;
            line_start  <= clk_enable && h_wrap;
            frame_start <= clk_enable && h_wrap && v_wrap;
            if (wr_en_n) begin
                wr_addr <= byte_cnt[2:0];
                wr_data <= data_in;
            end
        end
    end

    assign DMAO = (state_q != S_REQ);
    assign INT  = int_q;
    assign EFx  = !(((v_count >= V_START - 9'd4) && (v_count < V_START)) ||
                    ((v_count >= V_END - 9'd4) && (v_count < V_END)));

endmodule
